// File: rtl/apb_req_arbiter.sv
// Two-requester APB master. Requests are arbitrated round-robin in IDLE and
// the winner's command is latched. The controller then runs the SETUP/ACCESS
// phases, waits for iPready with a bounded timeout, and returns read data and
// a one-cycle ack to the requester that was granted.
`timescale 1ns/1ps
module apb_req_arbiter #(
    parameter int P_TIMEOUT = 255
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iReq0,
    input  logic        iReq1,
    input  logic        iWr0,
    input  logic        iWr1,
    input  logic [15:0] iAddr0,
    input  logic [15:0] iAddr1,
    input  logic [31:0] iWdata0,
    input  logic [31:0] iWdata1,
    output logic        oAck0,
    output logic        oAck1,
    output logic        oErr,
    output logic [31:0] oRdata,
    output logic        oPsel,
    output logic        oPenable,
    output logic        oPwrite,
    output logic [15:0] oPaddr,
    output logic [31:0] oPwdata,
    input  logic [31:0] iPrdata,
    input  logic        iPready
);

    // A timeout of 0 disables the timeout. The counter then keeps one bit so
    // that the declarations stay legal.
    localparam int          CW     = (P_TIMEOUT > 0) ? $clog2(P_TIMEOUT + 1) : 1;
    localparam logic [31:0] TO_LIM = 32'(P_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          last_q;
    logic          gnt_q;
    logic          wr_q;
    logic [1:0]    ack_q;
    logic          err_q;
    logic [31:0]   rdata_q;
    logic          psel_q;
    logic          penable_q;
    logic          pwrite_q;
    logic [15:0]   paddr_q;
    logic [31:0]   pwdata_q;

    logic [1:0]    req_vec;
    logic [1:0]    req_act;
    logic          any_req;
    logic          win;
    logic          sel_wr;
    logic [15:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic          timeout_hit;
    logic          cnt_sat;

    assign req_vec = {iReq1, iReq0};

    // A requester being acked this cycle is masked. This stops a request that is
    // still high during its own ack from being granted a second time.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_mask
            assign req_act[gi] = req_vec[gi] & ~ack_q[gi];
        end
    endgenerate

    // Round-robin pick: on a tie the requester that was not granted last wins.
    always_comb begin
        any_req = |req_act;
        win     = 1'b0;
        if (&req_act) begin
            win = ~last_q;
        end else begin
            win = req_act[1];
        end
        sel_wr    = win ? iWr1    : iWr0;
        sel_addr  = win ? iAddr1  : iAddr0;
        sel_wdata = win ? iWdata1 : iWdata0;
    end

    // The timeout fires on the ACCESS cycle that would bring the counter to P_TIMEOUT.
    always_comb begin
        cnt_sat     = (cnt_q == {CW{1'b1}});
        timeout_hit = (P_TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) >= TO_LIM);
    end

    // Transfer sequencer. All outputs are registered here.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            gnt_q     <= 1'b0;
            wr_q      <= 1'b0;
            ack_q     <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            ack_q <= '0;
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        state_q   <= ST_SETUP;
                        gnt_q     <= win;
                        last_q    <= win;
                        wr_q      <= sel_wr;
                        pwrite_q  <= sel_wr;
                        paddr_q   <= sel_addr;
                        pwdata_q  <= sel_wdata;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        cnt_q     <= '0;
                    end
                end
                ST_SETUP: begin
                    state_q   <= ST_ACCESS;
                    penable_q <= 1'b1;
                end
                ST_ACCESS: begin
                    if (iPready) begin
                        // Normal completion. It takes priority over a timeout in the same cycle.
                        state_q   <= ST_IDLE;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        pwrite_q  <= 1'b0;
                        ack_q     <= gnt_q ? 2'b10 : 2'b01;
                        if (!wr_q) begin
                            rdata_q <= iPrdata;
                        end
                    end else if (timeout_hit) begin
                        state_q   <= ST_IDLE;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        pwrite_q  <= 1'b0;
                        ack_q     <= gnt_q ? 2'b10 : 2'b01;
                        err_q     <= 1'b1;
                        rdata_q   <= '0;
                    end else if (!cnt_sat) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign oAck0    = ack_q[0];
    assign oAck1    = ack_q[1];
    assign oErr     = err_q;
    assign oRdata   = rdata_q;
    assign oPsel    = psel_q;
    assign oPenable = penable_q;
    assign oPwrite  = pwrite_q;
    assign oPaddr   = paddr_q;
    assign oPwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter, built with P_TIMEOUT = 4.
`timescale 1ns/1ps
module tb_apb_req_arbiter;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iReq0, iReq1, iWr0, iWr1;
    logic [15:0] iAddr0, iAddr1;
    logic [31:0] iWdata0, iWdata1;
    logic        oAck0, oAck1, oErr;
    logic [31:0] oRdata;
    logic        oPsel, oPenable, oPwrite;
    logic [15:0] oPaddr;
    logic [31:0] oPwdata;
    logic [31:0] iPrdata;
    logic        iPready;

    int checks = 0;
    int errors = 0;

    apb_req_arbiter #(.P_TIMEOUT(4)) dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iReq0   (iReq0),
        .iReq1   (iReq1),
        .iWr0    (iWr0),
        .iWr1    (iWr1),
        .iAddr0  (iAddr0),
        .iAddr1  (iAddr1),
        .iWdata0 (iWdata0),
        .iWdata1 (iWdata1),
        .oAck0   (oAck0),
        .oAck1   (oAck1),
        .oErr    (oErr),
        .oRdata  (oRdata),
        .oPsel   (oPsel),
        .oPenable(oPenable),
        .oPwrite (oPwrite),
        .oPaddr  (oPaddr),
        .oPwdata (oPwdata),
        .iPrdata (iPrdata),
        .iPready (iPready)
    );

    always #5 iClk = ~iClk;

    // Advance one rising edge, then settle 1 ns so outputs are sampled and inputs driven off the edge.
    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int ack_who [4];
    int ack_cyc [4];
    int nacks;
    int pen_cnt;

    initial begin
        iRst = 1'b1; iReq0 = 0; iReq1 = 0; iWr0 = 0; iWr1 = 0;
        iAddr0 = '0; iAddr1 = '0; iWdata0 = '0; iWdata1 = '0;
        iPrdata = '0; iPready = 1'b0;
        tick(); tick();

        // Reset state
        chk("rst_psel", oPsel, 0);
        chk("rst_penable", oPenable, 0);
        chk("rst_ack0", oAck0, 0);
        chk("rst_ack1", oAck1, 0);
        chk("rst_err", oErr, 0);
        chk("rst_rdata", oRdata, 0);
        chk("rst_paddr", oPaddr, 0);
        chk("rst_pwrite", oPwrite, 0);
        iRst = 1'b0;
        tick();

        // T1: write from requester 0, zero-wait slave
        iReq0 = 1; iWr0 = 1; iAddr0 = 16'h0000; iWdata0 = 32'h5A5A5A5A; iPready = 1;
        tick();
        chk("t1_setup_psel", oPsel, 1);
        chk("t1_setup_penable", oPenable, 0);
        chk("t1_setup_pwrite", oPwrite, 1);
        chk("t1_setup_paddr", oPaddr, 32'h0);
        chk("t1_setup_pwdata", oPwdata, 32'h5A5A5A5A);
        tick();
        chk("t1_access_penable", oPenable, 1);
        chk("t1_access_pwrite", oPwrite, 1);
        chk("t1_access_ack0", oAck0, 0);
        tick();
        chk("t1_ack0", oAck0, 1);
        chk("t1_ack1", oAck1, 0);
        chk("t1_err", oErr, 0);
        chk("t1_done_psel", oPsel, 0);
        chk("t1_done_pwrite", oPwrite, 0);
        $display("txn write req0 addr=%h wdata=%h ack0=%b err=%b", oPaddr, oPwdata, oAck0, oErr);
        iReq0 = 0; iPready = 0;
        tick();
        chk("t1_ack_pulse", oAck0, 0);
        chk("t1_idle_psel", oPsel, 0);

        // T2: read from requester 1, two wait states
        iReq1 = 1; iWr1 = 0; iAddr1 = 16'h000C; iPrdata = 32'hFFFFFFFF; iPready = 0;
        pen_cnt = 0;
        tick();
        chk("t2_setup_paddr", oPaddr, 32'h000C);
        chk("t2_setup_pwrite", oPwrite, 0);
        tick(); if (oPenable) pen_cnt++;
        chk("t2_ack_early1", oAck1, 0);
        tick(); if (oPenable) pen_cnt++;
        chk("t2_ack_early2", oAck1, 0);
        tick(); if (oPenable) pen_cnt++;
        iPready = 1;
        tick(); if (oPenable) pen_cnt++;
        chk("t2_penable_cycles", pen_cnt, 3);
        chk("t2_ack1", oAck1, 1);
        chk("t2_ack0", oAck0, 0);
        chk("t2_rdata", oRdata, 32'hFFFFFFFF);
        chk("t2_err", oErr, 0);
        $display("txn read req1 addr=%h rdata=%h ack1=%b err=%b", oPaddr, oRdata, oAck1, oErr);
        iReq1 = 0; iPready = 0;
        tick();

        // T3: timeout. Requester 0 reads with iPready stuck low.
        iReq0 = 1; iWr0 = 0; iAddr0 = 16'h0004; iPrdata = 32'h12345678;
        tick();
        chk("t3_setup_psel", oPsel, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_access_penable", oPenable, 1);
            chk("t3_no_early_ack", oAck0, 0);
        end
        tick();
        chk("t3_ack0", oAck0, 1);
        chk("t3_err", oErr, 1);
        chk("t3_rdata", oRdata, 0);
        chk("t3_psel", oPsel, 0);
        chk("t3_penable", oPenable, 0);
        $display("txn timeout req0 addr=%h ack0=%b err=%b rdata=%h", oPaddr, oAck0, oErr, oRdata);
        iReq0 = 0;
        tick();
        chk("t3_err_clear", oErr, 0);

        // T4: reset during ACCESS while requester 0 is held
        iReq0 = 1; iWr0 = 1; iAddr0 = 16'h0004; iWdata0 = 32'hDEADBEEF; iPready = 0;
        tick();
        tick();
        chk("t4_access_penable", oPenable, 1);
        iRst = 1;
        tick();
        chk("t4_rst_psel", oPsel, 0);
        chk("t4_rst_penable", oPenable, 0);
        chk("t4_rst_ack0", oAck0, 0);
        chk("t4_rst_pwrite", oPwrite, 0);
        chk("t4_rst_paddr", oPaddr, 0);
        chk("t4_rst_pwdata", oPwdata, 0);
        iRst = 0; iPready = 1;
        tick();
        chk("t4_resetup_psel", oPsel, 1);
        chk("t4_resetup_penable", oPenable, 0);
        chk("t4_resetup_paddr", oPaddr, 32'h0004);
        chk("t4_resetup_pwdata", oPwdata, 32'hDEADBEEF);
        tick();
        chk("t4_reaccess_penable", oPenable, 1);
        tick();
        chk("t4_ack0", oAck0, 1);
        chk("t4_err", oErr, 0);
        $display("txn write-after-reset req0 addr=%h wdata=%h ack0=%b", oPaddr, oPwdata, oAck0);
        iReq0 = 0; iPready = 0;
        tick();

        // T5: both requesters held high straight after reset
        iRst = 1;
        tick();
        iRst = 0; iPready = 1;
        iReq0 = 1; iWr0 = 1; iAddr0 = 16'h0000; iWdata0 = 32'hA0A0A0A0;
        iReq1 = 1; iWr1 = 1; iAddr1 = 16'h0004; iWdata1 = 32'hB1B1B1B1;
        nacks = 0;
        for (int cyc = 0; cyc < 40 && nacks < 4; cyc++) begin
            tick();
            if (oAck0 && oAck1) chk("t5_dual_ack", {oAck1, oAck0}, 2'b01);
            if (oAck0 || oAck1) begin
                ack_who[nacks] = oAck1 ? 1 : 0;
                ack_cyc[nacks] = cyc;
                $display("txn rr ack idx=%0d requester=%0d cycle=%0d", nacks, ack_who[nacks], cyc);
                nacks++;
                if (nacks == 4) begin
                    iReq0 = 0; iReq1 = 0;
                end
            end
        end
        chk("t5_ack_count", nacks, 4);
        if (nacks == 4) begin
            chk("t5_order0", ack_who[0], 0);
            chk("t5_order1", ack_who[1], 1);
            chk("t5_order2", ack_who[2], 0);
            chk("t5_order3", ack_who[3], 1);
            chk("t5_first_ack_cycle", ack_cyc[0], 2);
            chk("t5_gap01", ack_cyc[1] - ack_cyc[0], 3);
            chk("t5_gap12", ack_cyc[2] - ack_cyc[1], 3);
            chk("t5_gap23", ack_cyc[3] - ack_cyc[2], 3);
        end
        iPready = 0;
        tick();
        chk("t5_idle_after", oPsel, 0);

        // T6: requester inputs change after the grant and must be ignored
        iReq0 = 1; iWr0 = 1; iAddr0 = 16'h0000; iWdata0 = 32'h11111111;
        tick();
        iAddr0 = 16'h0004; iWdata0 = 32'h22222222;
        tick();
        chk("t6_access_paddr", oPaddr, 32'h0000);
        chk("t6_access_pwdata", oPwdata, 32'h11111111);
        tick();
        chk("t6_wait_paddr", oPaddr, 32'h0000);
        iPready = 1;
        tick();
        chk("t6_ack0", oAck0, 1);
        chk("t6_ack_paddr", oPaddr, 32'h0000);
        chk("t6_ack_pwdata", oPwdata, 32'h11111111);
        $display("txn write-latched req0 addr=%h wdata=%h ack0=%b", oPaddr, oPwdata, oAck0);
        iReq0 = 0; iPready = 0;
        tick();
        chk("t6_idle_paddr_hold", oPaddr, 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
